// File: rtl/pe_packetizer_rr.sv
// PE output packetizer: NUM_PSUMS psum packets then one filter packet per round, 1-cycle registered output.
// Optional PE_PKT_SEQ_TAG_EN puts {round_cnt[3:0], psum_cnt[3:0]} in the low pad byte of psum packets.
module pe_packetizer_rr #(
  parameter int DWIDTH = 8,
  parameter int TAPS = 3,
  parameter int AWIDTH = 3,
  parameter int PAYLOAD_W = 40,
  parameter int FILT_W = TAPS * DWIDTH,
  parameter int PWIDTH = 1 + 2 * AWIDTH + PAYLOAD_W,
  parameter int NUM_PSUMS = 3,
  parameter int NUM_ROUNDS = 0,
  parameter logic [AWIDTH-1:0] THIS_ADDR = 3,
  parameter logic [AWIDTH-1:0] NEXT_ADDR = 1,
  parameter logic [AWIDTH-1:0] ADDER_ADDR = 4,
  parameter logic [31:0] PSUM_PAD = 32'h0000FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [DWIDTH-1:0] psum_data,
  input  logic              filt_valid,
  output logic              filt_ready,
  input  logic [FILT_W-1:0] filt_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [PWIDTH-1:0] pkt_data,
  output logic              round_done,
  output logic              done
);

  localparam int PAD_W = PAYLOAD_W - DWIDTH;
  localparam int RC_W = 16;

  typedef enum logic [1:0] {S_PSUM, S_FILT, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [7:0]        psum_cnt;
  logic [RC_W-1:0]   round_cnt;
  logic              slot_free;
  logic              psum_acc;
  logic              filt_fwd;
  logic              psum_wrap;
  logic              rounds_hit;
  logic [PAD_W-1:0]  pad;
  logic [PWIDTH-1:0] load_dat;

  assign slot_free  = !pkt_valid || pkt_ready;
  assign psum_wrap  = (psum_cnt == 8'(NUM_PSUMS - 1));
  assign rounds_hit = (NUM_ROUNDS != 0) && ((round_cnt + 1'b1) == RC_W'(NUM_ROUNDS));
  assign psum_acc   = psum_valid && psum_ready;
  // Filters taken in DRAIN are swallowed, so only FILT-state accepts produce a packet.
  assign filt_fwd   = filt_valid && filt_ready && (state == S_FILT);
  assign done       = (state == S_DRAIN);

  always_comb begin
    pad = PAD_W'(PSUM_PAD);
`ifdef PE_PKT_SEQ_TAG_EN
    pad[7:0] = {round_cnt[3:0], psum_cnt[3:0]};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_PSUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    psum_ready = 1'b0;
    filt_ready = 1'b0;
    load_dat   = {1'b1, ADDER_ADDR, THIS_ADDR, pad, psum_data};
    case (state)
      S_PSUM: begin
        psum_ready = slot_free;
        if (psum_acc && psum_wrap) state_nxt = S_FILT;
      end
      S_FILT: begin
        filt_ready = slot_free;
        load_dat   = {1'b0, NEXT_ADDR, THIS_ADDR, PAYLOAD_W'(filt_data)};
        if (filt_fwd) state_nxt = rounds_hit ? S_DRAIN : S_PSUM;
      end
      S_DRAIN: begin
        psum_ready = slot_free;
        filt_ready = 1'b1;
      end
      default: state_nxt = S_PSUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_cnt   <= '0;
      round_cnt  <= '0;
      pkt_valid  <= 1'b0;
      pkt_data   <= '0;
      round_done <= 1'b0;
    end else begin
      round_done <= filt_fwd;
      if (psum_acc) psum_cnt <= psum_wrap ? 8'd0 : psum_cnt + 8'd1;
      // Once NUM_ROUNDS is hit the FSM parks in DRAIN, which holds round_cnt there.
      if (filt_fwd) round_cnt <= round_cnt + 1'b1;
      if (psum_acc || filt_fwd) begin
        pkt_valid <= 1'b1;
        pkt_data  <= load_dat;
      end else if (pkt_ready) begin
        pkt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_packetizer_rr.sv
// Scoreboard bench for pe_packetizer_rr with NUM_ROUNDS=2; honours PE_PKT_SEQ_TAG_EN if defined.
module tb_pe_packetizer_rr;

  localparam int NPS = 3;
  localparam int NR  = 2;
  localparam int NP  = 15;
  localparam int NF  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psum_valid = 1'b0;
  logic        psum_ready;
  logic [7:0]  psum_data = '0;
  logic        filt_valid = 1'b0;
  logic        filt_ready;
  logic [23:0] filt_data = '0;
  logic        pkt_valid;
  logic        pkt_ready = 1'b1;
  logic [46:0] pkt_data;
  logic        round_done;
  logic        done;

  int tests = 0;
  int fails = 0;
  int rd_seen = 0;
  int rdy_mode = 0;
  logic [46:0] exp_q[$];
  logic [7:0]  psd[NP];
  logic [23:0] fd[NF];

  pe_packetizer_rr #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .round_done(round_done), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [46:0] psum_pkt(input int rnd, input int idx, input logic [7:0] d);
    logic [31:0] pad;
    logic [7:0] tag;
    pad = 32'h0000FFFF;
`ifdef PE_PKT_SEQ_TAG_EN
    tag = {4'(rnd), 4'(idx)};
    pad[7:0] = tag;
`else
    tag = 8'(rnd + idx);
`endif
    return {1'b1, 3'd4, 3'd3, pad, d};
  endfunction

  function automatic logic [46:0] filt_pkt(input logic [23:0] f);
    return {1'b0, 3'd1, 3'd3, 16'h0000, f};
  endfunction

  // Downstream ready: random, held low, or held high; changes just after the active edge.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      pkt_ready = ($urandom_range(0, 99) < 65);
    else if (rdy_mode == 1) pkt_ready = 1'b0;
    else                    pkt_ready = 1'b1;
  end

  logic        prev_stall = 1'b0;
  logic        prev_load = 1'b0;
  logic [46:0] prev_dat = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_load  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(pkt_valid), 64'd1);
        check("hold_data", 64'(pkt_data), 64'(prev_dat));
      end
      if (prev_load) check("latency_1", 64'(pkt_valid), 64'd1);
      if (!done) check("excl_ready", 64'(psum_ready && filt_ready), 64'd0);
      if (round_done) begin
        rd_seen++;
        check("done_vs_round", 64'(done), 64'(rd_seen >= NR));
      end
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) check("unexpected_pkt", 64'(pkt_data), 64'd0);
        else check("pkt", 64'(pkt_data), 64'(exp_q.pop_front()));
      end
      prev_stall = pkt_valid && !pkt_ready;
      prev_dat   = pkt_data;
      prev_load  = (psum_valid && psum_ready) || (filt_valid && filt_ready && !done);
    end
  end

  task automatic send_psum(input logic [7:0] d);
    int n = 0;
    psum_data = d;
    psum_valid = 1'b1;
    @(negedge clk);
    while (!psum_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("psum_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 psum_valid = 1'b0;
  endtask

  task automatic send_filt(input logic [23:0] f);
    int n = 0;
    filt_data = f;
    filt_valid = 1'b1;
    @(negedge clk);
    while (!filt_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("filt_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 filt_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #5;
    check("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    check("rst_pkt_data", 64'(pkt_data), 64'd0);
    check("rst_round_done", 64'(round_done), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_filt_ready", 64'(filt_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First round is the directed vector; the rest is random.
    for (int k = 0; k < NP; k++) psd[k] = (k < 3) ? 8'(k + 5) : 8'($urandom);
    fd[0] = 24'h010203;
    for (int j = 1; j < NF; j++) fd[j] = 24'($urandom);

    // Output order follows from the rules alone: NPS psums, then the round's filter while rounds remain.
    for (int r = 0; r * NPS < NP; r++) begin
      for (int i = 0; i < NPS; i++)
        if (r * NPS + i < NP) exp_q.push_back(psum_pkt((r < NR) ? r : NR, i, psd[r * NPS + i]));
      if (r < NR && r < NF) exp_q.push_back(filt_pkt(fd[r]));
    end

    fork
      for (int k = 0; k < NP; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_psum(psd[k]);
      end
      // Filter 0 is offered at once, well before the round's psums are in.
      for (int j = 0; j < NF; j++) begin
        if (j > 0) repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        send_filt(fd[j]);
      end
    join
    wait_drain();
    check("round_done_count", 64'(rd_seen), 64'(NR));
    check("done_sticky", 64'(done), 64'd1);

    // Stall a packet, then reset mid-cycle: it must vanish and counters restart.
    rdy_mode = 1;
    @(posedge clk);
    #2;
    send_psum(8'hAA);
    repeat (2) @(posedge clk);
    #2 check("stalled_valid", 64'(pkt_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(pkt_valid), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 2;
    exp_q.push_back(psum_pkt(0, 0, 8'h3C));
    exp_q.push_back(psum_pkt(0, 1, 8'hC3));
    send_psum(8'h3C);
    send_psum(8'hC3);
    wait_drain();
    check("post_rst_q_empty", 64'(exp_q.size()), 64'd0);
    check("post_rst_filt_ready", 64'(filt_ready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_packetizer_rr.md
Name: pe_packetizer_rr

Overview:
- Clocked, parametrised successor to the PE output packetizer.
- Merges one PE's partial-sum stream and its filter-forward stream into single NoC packets of the form {type, dest, src, payload}.
- Emits NUM_PSUMS psum packets to the adder node, then one filter packet to the next PE in the ring, and repeats.
- Adds a finite round count with post-completion filter drop, plus registered valid/ready output with backpressure.

Parameters:
- DWIDTH, 8: psum and filter-tap width.
- TAPS, 3: taps per filter frame; FILT_W = TAPS*DWIDTH.
- AWIDTH, 3: node address width.
- PAYLOAD_W, 40: payload field width; must be >= FILT_W and > DWIDTH.
- PWIDTH, 1+2*AWIDTH+PAYLOAD_W (47 by default): packet width.
- NUM_PSUMS, 3: psum packets per round, 1..255.
- NUM_ROUNDS, 0: filter forwards before completion; 0 = unlimited.
- THIS_ADDR, 3: source address of this PE.
- NEXT_ADDR, 1: destination for filter packets.
- ADDER_ADDR, 4: destination for psum packets.
- PSUM_PAD, 32'h0000FFFF: constant pad placed above the psum, truncated or zero-extended to PAYLOAD_W-DWIDTH.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- psum_valid, in, 1: psum offered.
- psum_ready, out, 1: psum accepted when psum_valid && psum_ready.
- psum_data, in, DWIDTH: partial sum.
- filt_valid, in, 1: filter frame offered.
- filt_ready, out, 1: frame accepted when filt_valid && filt_ready.
- filt_data, in, FILT_W: frame, tap0 in the MSBs.
- pkt_valid, out, 1: packet available.
- pkt_ready, in, 1: downstream accepts.
- pkt_data, out, PWIDTH: packet.
- round_done, out, 1: one-cycle pulse when a filter packet is loaded.
- done, out, 1: NUM_ROUNDS reached (sticky).

Behaviour:
- Reset (async assert, sync release): state=PSUM, psum_cnt=0, round_cnt=0, pkt_valid=0, pkt_data=0, round_done=0, done=0.
- Output register:
  - slot_free = !pkt_valid || pkt_ready.
  - An accepted input loads the register the same edge; pkt_valid rises the next cycle (latency 1).
  - pkt_data is held stable while pkt_valid && !pkt_ready.
  - Full throughput of 1 packet/cycle when pkt_ready stays high.
- State PSUM:
  - psum_ready = slot_free; filt_ready = 0.
  - On accept: pkt_data = {1'b1, ADDER_ADDR, THIS_ADDR, PSUM_PAD, psum_data}; psum_cnt++.
  - When the accept makes psum_cnt reach NUM_PSUMS: psum_cnt=0, go to FILT.
- State FILT:
  - filt_ready = slot_free; psum_ready = 0.
  - On accept: pkt_data = {1'b0, NEXT_ADDR, THIS_ADDR, zero-extended filt_data}; round_done pulses; round_cnt++; go to PSUM.
  - If NUM_ROUNDS != 0 and round_cnt reaches NUM_ROUNDS: set done, go to DRAIN.
- State DRAIN (done=1):
  - psum path behaves exactly as in PSUM, cycling through the same count.
  - Filter frames are accepted with filt_ready=1 regardless of slot_free, and dropped (no packet, no round_done).
  - The final filter is not forwarded past the last round.
  - Only reset leaves DRAIN.
- psum_ready and filt_ready are never both 1 in PSUM/FILT. An input offered in the wrong state waits; there is no reordering.
- round_cnt saturates; with NUM_ROUNDS=0 it wraps and done never sets.
- Reset mid-packet: any stalled packet is discarded and pkt_valid drops immediately.

Optional Feature:
- Macro PE_PKT_SEQ_TAG_EN.
- Defined: in psum packets, the low 8 bits of the pad field carry {round_cnt[3:0], psum_cnt[3:0]} (values before increment); the upper pad bits remain PSUM_PAD. Filter packets are unchanged.
- Undefined: the pad field equals PSUM_PAD exactly.

Test Plan:
- Defaults, pkt_ready=1; psums 5,6,7, then filter {1,2,3}.
  - Expect 0x4_3_000000FFFF_05, then _06, _07, then {0,001,011, 0x000010203}.
  - round_done pulses once; each packet appears 1 cycle after its accept.
- Backpressure: pkt_ready=0 for 4 cycles after the first psum.
  - pkt_data held constant; psum_ready=0; no loss or duplication once ready returns.
- Filter offered early (during psum 1): filt_ready stays 0 until 3 psums are accepted, then the filter packet follows psum 3.
- NUM_ROUNDS=2: run 3 rounds.
  - done rises after the 2nd filter packet; the 3rd filter is consumed with no packet; psums are still forwarded.
- Reset asserted with a stalled packet: pkt_valid=0 asynchronously; after release, first accepted psum has psum_cnt=0.
- PE_PKT_SEQ_TAG_EN, round 1, psum index 2: pad low byte = 0x12.
